// File: rtl/layer_priority_sched_pkg.sv
// Shared types, constants and colour helper for the layer priority scheduler.
package layer_pkg;

  localparam int unsigned DEF_NUM_LAYERS = 6;
  localparam int unsigned IDX_W          = 3;
  localparam int unsigned RGB332_W       = 8;
  localparam int unsigned CH_W           = 8;

  typedef logic [IDX_W-1:0] layer_idx_t;

  localparam layer_idx_t BG_LAYER = 3'd7;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_STAGED = 2'd1,
    CFG_COMMIT = 2'd2
  } cfg_state_t;

  typedef struct packed {
    logic [CH_W-1:0] red;
    logic [CH_W-1:0] green;
    logic [CH_W-1:0] blue;
  } rgb888_t;

  // Replicate the LSB of each field so full-scale RGB332 maps to 0xFF.
  function automatic rgb888_t rgb332_expand(input logic [RGB332_W-1:0] c);
    rgb888_t px;
    px.red   = {c[7:5], {5{c[5]}}};
    px.green = {c[4:2], {5{c[2]}}};
    px.blue  = {c[1:0], {6{c[0]}}};
    return px;
  endfunction

endpackage

// File: rtl/layer_priority_sched_if.sv
// Pixel, configuration and output bundle of the layer priority scheduler.
interface layer_priority_sched_if
  import layer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS
);

  logic                             startOfFrame;
  logic [NUM_LAYERS-1:0]            layerRequest;
  logic [RGB332_W*NUM_LAYERS-1:0]   layerRGB;
  logic [RGB332_W-1:0]              backGroundRGB;
  logic                             cfgValid;
  logic                             cfgReady;
  layer_idx_t                       cfgSlot;
  layer_idx_t                       cfgLayer;
  logic [CH_W-1:0]                  redOut;
  logic [CH_W-1:0]                  greenOut;
  logic [CH_W-1:0]                  blueOut;
  layer_idx_t                       drawnLayer;
  logic [NUM_LAYERS-1:0]            collision;

  modport master (
    output startOfFrame, layerRequest, layerRGB, backGroundRGB,
    output cfgValid, cfgSlot, cfgLayer,
    input  cfgReady, redOut, greenOut, blueOut, drawnLayer, collision
  );

  modport slave (
    input  startOfFrame, layerRequest, layerRGB, backGroundRGB,
    input  cfgValid, cfgSlot, cfgLayer,
    output cfgReady, redOut, greenOut, blueOut, drawnLayer, collision
  );

endinterface

// File: rtl/layer_priority_sched_encoder.sv
// Combinational slot scan: lowest slot whose layer is requesting wins.
module layer_priority_encoder
  import layer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS
) (
  input  layer_idx_t [NUM_LAYERS-1:0] prio_table,
  input  logic [NUM_LAYERS-1:0]       req,
  output layer_idx_t                  winner_c,
  output logic                        found_c
);

  logic [7:0] req_ext;

  // Scan from the highest slot down so the lowest matching slot overrides.
  always_comb begin
    req_ext  = 8'(req);
    winner_c = BG_LAYER;
    found_c  = 1'b0;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if ((32'(prio_table[s]) < NUM_LAYERS) && req_ext[prio_table[s]]) begin
        winner_c = prio_table[s];
        found_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_priority_sched.sv
// Layer priority scheduler with double-buffered priority table committed at frame start.
// Optional collision flags compiled in with `define LAYER_COLLISION_DETECT_EN.
module layer_priority_sched
  import layer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = DEF_NUM_LAYERS,
  parameter int unsigned PLAYER_LAYER = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  layer_priority_sched_if.slave  bus
);

  cfg_state_t                  state_q, state_d;
  layer_idx_t [NUM_LAYERS-1:0] shadow_q, shadow_d;
  layer_idx_t [NUM_LAYERS-1:0] active_q, active_d;
  logic                        pend_q, pend_d;
  logic                        cfg_ready_q;
  logic                        cfg_fire_c;
  logic                        slot_ok_c;

  layer_idx_t                  win_c;
  logic                        found_c;
  logic [RGB332_W-1:0]         rgb_sel_c;
  rgb888_t                     px_q;
  layer_idx_t                  drawn_q;

  assign cfg_fire_c = bus.cfgValid & cfg_ready_q;
  assign slot_ok_c  = 32'(bus.cfgSlot) < NUM_LAYERS;

  // Config FSM; pend_q remembers a write that landed in the commit cycle.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (cfg_fire_c && slot_ok_c) begin
      shadow_d[bus.cfgSlot] = bus.cfgLayer;
    end
    case (state_q)
      CFG_IDLE: begin
        if (cfg_fire_c && slot_ok_c) begin
          state_d = CFG_STAGED;
        end
      end
      CFG_STAGED: begin
        if (bus.startOfFrame) begin
          active_d = shadow_q;
          state_d  = CFG_COMMIT;
          pend_d   = cfg_fire_c && slot_ok_c;
        end
      end
      CFG_COMMIT: begin
        state_d = pend_q ? CFG_STAGED : CFG_IDLE;
        pend_d  = 1'b0;
      end
      default: begin
        state_d = CFG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CFG_IDLE;
      pend_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= layer_idx_t'(i);
        active_q[i] <= layer_idx_t'(i);
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cfg_ready_q <= (state_d != CFG_COMMIT);
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  layer_priority_encoder #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_enc (
    .prio_table (active_q),
    .req        (bus.layerRequest),
    .winner_c   (win_c),
    .found_c    (found_c)
  );

  always_comb begin
    rgb_sel_c = bus.backGroundRGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (found_c && (32'(win_c) == i)) begin
        rgb_sel_c = bus.layerRGB[RGB332_W*i +: RGB332_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px_q    <= '0;
      drawn_q <= BG_LAYER;
    end else begin
      px_q    <= rgb332_expand(rgb_sel_c);
      drawn_q <= found_c ? win_c : BG_LAYER;
    end
  end

  assign bus.redOut     = px_q.red;
  assign bus.greenOut   = px_q.green;
  assign bus.blueOut    = px_q.blue;
  assign bus.drawnLayer = drawn_q;
  assign bus.cfgReady   = cfg_ready_q;

`ifdef LAYER_COLLISION_DETECT_EN
  localparam logic [NUM_LAYERS-1:0] PLAYER_MASK = NUM_LAYERS'(1) << PLAYER_LAYER;

  logic [NUM_LAYERS-1:0] coll_q, coll_d;

  // Frame start clears old flags but still records overlaps from that pixel.
  always_comb begin
    coll_d = bus.startOfFrame ? '0 : coll_q;
    if (bus.layerRequest[PLAYER_LAYER]) begin
      coll_d = coll_d | (bus.layerRequest & ~PLAYER_MASK);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign bus.collision = coll_q;
`else
  assign bus.collision = '0;
`endif

endmodule

// File: tb/tb_layer_priority_sched.sv
// Directed bench for layer_priority_sched with hand-computed expectations.
module tb_layer_priority_sched;
  import layer_pkg::*;

  localparam int unsigned NL = 6;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  layer_priority_sched_if #(.NUM_LAYERS(NL)) bus ();

  layer_priority_sched #(
    .NUM_LAYERS   (NL),
    .PLAYER_LAYER (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] slot, input logic [2:0] layer);
    bus.cfgValid = 1'b1;
    bus.cfgSlot  = slot;
    bus.cfgLayer = layer;
    tick();
    bus.cfgValid = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.startOfFrame  = 1'b0;
    bus.layerRequest  = '0;
    bus.layerRGB      = '0;
    bus.backGroundRGB = '0;
    bus.cfgValid      = 1'b0;
    bus.cfgSlot       = '0;
    bus.cfgLayer      = '0;
    tick();
    tick();

    check("rst_red",   32'(bus.redOut),     32'h0);
    check("rst_green", 32'(bus.greenOut),   32'h0);
    check("rst_blue",  32'(bus.blueOut),    32'h0);
    check("rst_drawn", 32'(bus.drawnLayer), 32'd7);
    check("rst_coll",  32'(bus.collision),  32'h0);
    check("rst_ready", 32'(bus.cfgReady),   32'h0);
    reset = 1'b0;

    // Identity table, layers 1 and 2 requesting: layer 1 wins
    bus.layerRequest         = 6'b000110;
    bus.layerRGB[8*1 +: 8]   = 8'hE0;
    bus.layerRGB[8*2 +: 8]   = 8'h1C;
    bus.layerRGB[8*4 +: 8]   = 8'h03;
    tick();
    check("id_red",   32'(bus.redOut),     32'hFF);
    check("id_green", 32'(bus.greenOut),   32'h00);
    check("id_blue",  32'(bus.blueOut),    32'h00);
    check("id_drawn", 32'(bus.drawnLayer), 32'd1);
    check("id_ready", 32'(bus.cfgReady),   32'h1);

    // Slot0 <- layer4 mid-frame: only takes effect after frame start
    bus.layerRequest = 6'b010010;
    cfg_write(3'd0, 3'd4);
    check("stage_drawn0", 32'(bus.drawnLayer), 32'd1);
    tick();
    check("stage_drawn1", 32'(bus.drawnLayer), 32'd1);
    check("stage_ready",  32'(bus.cfgReady),   32'h1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("sof_drawn",    32'(bus.drawnLayer), 32'd1);
    check("commit_ready", 32'(bus.cfgReady),   32'h0);
    tick();
    check("new_drawn", 32'(bus.drawnLayer), 32'd4);
    check("new_blue",  32'(bus.blueOut),    32'hFF);
    check("new_red",   32'(bus.redOut),     32'h00);
    check("post_ready", 32'(bus.cfgReady),  32'h1);

    // Layer 0 now sits in no slot: background shown
    bus.layerRequest  = 6'b000001;
    bus.backGroundRGB = 8'hE0;
    tick();
    check("unmapped_drawn", 32'(bus.drawnLayer), 32'd7);
    check("unmapped_red",   32'(bus.redOut),     32'hFF);

    // Write coinciding with frame start in IDLE waits for the next frame
    bus.layerRequest = 6'b010100;
    bus.startOfFrame = 1'b1;
    cfg_write(3'd0, 3'd2);
    bus.startOfFrame = 1'b0;
    check("coinc_drawn0", 32'(bus.drawnLayer), 32'd4);
    tick();
    check("coinc_drawn1", 32'(bus.drawnLayer), 32'd4);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("coinc_sof", 32'(bus.drawnLayer), 32'd4);
    tick();
    check("coinc_drawn2", 32'(bus.drawnLayer), 32'd2);
    check("coinc_green",  32'(bus.greenOut),   32'hFF);

    // Out-of-range slot: handshake completes, no staging, no commit
    cfg_write(3'd6, 3'd0);
    check("badslot_ready0", 32'(bus.cfgReady), 32'h1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("badslot_ready1", 32'(bus.cfgReady), 32'h1);
    tick();
    check("badslot_drawn", 32'(bus.drawnLayer), 32'd2);

    // Empty every slot: background always wins
    for (int i = 0; i < 6; i++) begin
      cfg_write(3'(i), 3'd7);
    end
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame  = 1'b0;
    bus.layerRequest  = 6'b111111;
    bus.backGroundRGB = 8'h03;
    tick();
    check("empty_blue",  32'(bus.blueOut),    32'hFF);
    check("empty_red",   32'(bus.redOut),     32'h00);
    check("empty_green", 32'(bus.greenOut),   32'h00);
    check("empty_drawn", 32'(bus.drawnLayer), 32'd7);

    // Reset while STAGED discards the staged write and restores identity
    cfg_write(3'd0, 3'd3);
    reset = 1'b1;
    tick();
    check("rst2_ready", 32'(bus.cfgReady), 32'h0);
    tick();
    reset            = 1'b0;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    bus.layerRequest = 6'b001001;
    tick();
    check("rst2_drawn",  32'(bus.drawnLayer), 32'd0);
    check("rst2_ready1", 32'(bus.cfgReady),   32'h1);

    // Collision flags: player layer 1 overlapping layer 3
    bus.layerRequest = 6'b001010;
    tick();
    bus.layerRequest = 6'b000000;
    tick();
`ifdef LAYER_COLLISION_DETECT_EN
    check("coll_set0", 32'(bus.collision), 32'h08);
    tick();
    check("coll_set1", 32'(bus.collision), 32'h08);
`else
    check("coll_off0", 32'(bus.collision), 32'h00);
    tick();
    check("coll_off1", 32'(bus.collision), 32'h00);
`endif
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    check("coll_clr", 32'(bus.collision), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_priority_sched.md
LAYER_PRIORITY_SCHED -- requirements
Module: layer_priority_sched

Interface
REQ-001 Parameter NUM_LAYERS, default 6: number of drawable layers; index 0..NUM_LAYERS-1.
REQ-002 Parameter PLAYER_LAYER, default 1: layer index used as the collision reference.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 startOfFrame  in  1  one-cycle pulse at first pixel of each frame.
REQ-006 layerRequest  in  NUM_LAYERS  per-layer drawing request for current pixel.
REQ-007 layerRGB  in  8*NUM_LAYERS  packed RGB332 per layer; layer i at bits [8i+7:8i].
REQ-008 backGroundRGB  in  8  RGB332 used when no enabled layer requests.
REQ-009 cfgValid / cfgReady  in / out  1 / 1  priority-table write handshake; transfer when both high.
REQ-010 cfgSlot  in  3  priority slot to write; 0 = highest priority.
REQ-011 cfgLayer  in  3  layer index placed in cfgSlot; value >= NUM_LAYERS marks slot empty.
REQ-012 redOut, greenOut, blueOut  out  8 each  expanded 24-bit colour.
REQ-013 drawnLayer  out  3  winning layer index; 7 = background.
REQ-014 collision  out  NUM_LAYERS  sticky per-frame collision flags.

Function
REQ-015 Each cycle, scan slots 0..NUM_LAYERS-1 in order; the first slot whose layer has layerRequest high wins; no winner selects backGroundRGB.
REQ-016 Selected RGB, drawnLayer registered: 1-cycle latency from inputs to outputs.
REQ-017 Expansion: red={c[7:5],5x c[5]}, green={c[4:2],5x c[2]}, blue={c[1:0],6x c[0]}.
REQ-018 Same layer in several slots: lowest slot governs; layer in no slot never drawn.
REQ-019 Two tables: shadow (written by cfg) and active (used by REQ-015); the active table changes only at commit.
REQ-020 Config FSM states IDLE, STAGED, COMMIT; IDLE->STAGED on accepted write; STAGED->COMMIT on startOfFrame; COMMIT->IDLE next cycle.
REQ-021 COMMIT copies shadow to active; the new table governs pixels presented the cycle after startOfFrame.
REQ-022 cfgReady high in IDLE and STAGED, low in COMMIT and during reset.
REQ-023 Write accepted in the same cycle as startOfFrame updates shadow, is excluded from that commit; FSM goes to STAGED (next frame).
REQ-024 startOfFrame in IDLE: no table change, FSM stays IDLE.
REQ-025 cfgSlot >= NUM_LAYERS: handshake completes, write discarded, FSM state unchanged.

Reset
REQ-026 On reset: shadow and active tables = identity (slot i -> layer i); FSM IDLE.
REQ-027 On reset: redOut, greenOut, blueOut = 0; drawnLayer = 7; collision = 0; cfgReady = 0.
REQ-028 Reset mid-STAGED discards staged writes; no commit follows.

Configuration
REQ-029 Macro LAYER_COLLISION_DETECT_EN compiled in: collision[k] set when layerRequest[PLAYER_LAYER] and layerRequest[k] high together, k != PLAYER_LAYER.
REQ-030 With macro: collision cleared on startOfFrame; requests in that same cycle set bits for the new frame.
REQ-031 Without macro: collision tied to 0; no collision logic synthesised.

Structure
REQ-032 Package layer_pkg holds NUM_LAYERS default, BG_LAYER=7, layer_idx_t, cfg FSM enum, RGB332 expansion function.
REQ-033 Sub-module layer_priority_encoder: combinational active table + requests -> winner index, found flag.

Verification
REQ-034 Reset, identity table, requests 6'b000110, RGB1=0xE0, RGB2=0x1C -> next cycle red=0xFF, green=0, blue=0, drawnLayer=1.
REQ-035 Write slot0=layer4 mid-frame, requests 6'b010010 -> layer 1 drawn until startOfFrame; from cycle after pulse drawnLayer=4.
REQ-036 cfgValid with startOfFrame in same cycle -> no change that frame; change applied at following startOfFrame.
REQ-037 All slots empty (cfgLayer=7), requests 6'b111111, background 0x03 -> blue=0xFF, red=green=0, drawnLayer=7.
REQ-038 Macro on: requests 6'b001010 one cycle -> collision=6'b001000 until next startOfFrame, then 0.
REQ-039 Reset asserted while STAGED, then startOfFrame -> active table identity, cfgReady low during reset, high after.
